// File: rtl/mm_port_arbiter_pkg.sv
// rtl/mm_port_arbiter_pkg.sv - shared memory-interface widths, stage state and request/response bodies
// Contents:
//   NUM_REQ_DEF  default number of upstream requesters
//   PADDR_W      physical address width
//   BLOCK_W      data block width (one 16-byte line)
//   stage_state_e, mem_req_body_t, mem_res_body_t
package mm_port_arbiter_pkg;

   localparam int NUM_REQ_DEF = 4;
   localparam int PADDR_W     = 64;
   localparam int BLOCK_W     = 128;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } stage_state_e;

   typedef struct packed {
      logic               is_write;
      logic [PADDR_W-1:0] paddr;
      logic [BLOCK_W-1:0] data;
   } mem_req_body_t;

   typedef struct packed {
      logic [PADDR_W-1:0] paddr;
      logic [BLOCK_W-1:0] data;
   } mem_res_body_t;

endpackage

// File: rtl/mm_port_arbiter_if.sv
// rtl/mm_port_arbiter_if.sv - upstream, downstream and status signals of the memory port arbiter
// Groups:
//   req_*      per-requester request handshake and fields
//   res_*      shared registered read response, res_valid one-hot per requester
//   mem_req_*  downstream memory request, tag = {requester index, req_id}
//   mem_res_*  downstream read response
//   err_unexpected  sticky response-without-outstanding-read flag
// Modports: slave = arbiter view, master = environment view.
interface mm_port_arbiter_if
   import mm_port_arbiter_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int ID_W    = 4
);
   localparam int TAG_W = $clog2(NUM_REQ) + ID_W;

   logic [NUM_REQ-1:0]              req_valid;
   logic [NUM_REQ-1:0]              req_ready;
   logic [NUM_REQ-1:0]              req_is_write;
   logic [NUM_REQ-1:0][PADDR_W-1:0] req_paddr;
   logic [NUM_REQ-1:0][ID_W-1:0]    req_id;
   logic [NUM_REQ-1:0][BLOCK_W-1:0] req_data;

   logic [NUM_REQ-1:0]              res_valid;
   logic [ID_W-1:0]                 res_id;
   logic [PADDR_W-1:0]              res_paddr;
   logic [BLOCK_W-1:0]              res_data;

   logic                            mem_req_valid;
   logic                            mem_req_ready;
   logic                            mem_req_is_write;
   logic [PADDR_W-1:0]              mem_req_paddr;
   logic [TAG_W-1:0]                mem_req_tag;
   logic [BLOCK_W-1:0]              mem_req_data;

   logic                            mem_res_valid;
   logic [TAG_W-1:0]                mem_res_tag;
   logic [PADDR_W-1:0]              mem_res_paddr;
   logic [BLOCK_W-1:0]              mem_res_data;

   logic                            err_unexpected;

   modport slave (
      input  req_valid, req_is_write, req_paddr, req_id, req_data,
      output req_ready,
      output res_valid, res_id, res_paddr, res_data,
      output mem_req_valid, mem_req_is_write, mem_req_paddr, mem_req_tag, mem_req_data,
      input  mem_req_ready,
      input  mem_res_valid, mem_res_tag, mem_res_paddr, mem_res_data,
      output err_unexpected
   );

   modport master (
      output req_valid, req_is_write, req_paddr, req_id, req_data,
      input  req_ready,
      input  res_valid, res_id, res_paddr, res_data,
      input  mem_req_valid, mem_req_is_write, mem_req_paddr, mem_req_tag, mem_req_data,
      output mem_req_ready,
      output mem_res_valid, mem_res_tag, mem_res_paddr, mem_res_data,
      input  err_unexpected
   );

endinterface

// File: rtl/mm_port_arbiter_rr_select.sv
// rtl/mm_port_arbiter_rr_select.sv - round-robin pick of one eligible requester starting at a pointer
// Ports:
//   i_eligible  per-requester eligibility
//   i_ptr       highest-priority index for this cycle
//   o_grant     one-hot winner (zero when nothing eligible)
//   o_found     a winner exists
module mm_port_arbiter_rr_select #(
   parameter int N     = 4,
   parameter int PTR_W = 2
)(
   input  logic [N-1:0]     i_eligible,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [N-1:0]     o_grant,
   output logic             o_found
);

   // Priority order is ptr, ptr+1, ... wrapping; inner loop keeps every
   // bit-select constant so no variable indexing is needed.
   always_comb begin
      o_grant = '0;
      o_found = 1'b0;
      for (int k = 0; k < N; k++) begin
         for (int j = 0; j < N; j++) begin
            if (!o_found && (j == ((int'(i_ptr) + k) % N)) && i_eligible[j]) begin
               o_grant[j] = 1'b1;
               o_found    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/mm_port_arbiter.sv
// rtl/mm_port_arbiter.sv - round-robin arbiter of upstream requesters onto one memory port
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-high reset
//   bus    mm_port_arbiter_if.slave: req_* in, res_* out, mem_req_* out, mem_res_* in, err_unexpected out
// A single-entry output stage (EMPTY/FULL) holds the granted request; reads are
// limited to MAX_OUTST in flight per requester; read responses are routed back
// by the requester index carried in the upper tag bits.
module mm_port_arbiter
   import mm_port_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = NUM_REQ_DEF,
   parameter int ID_W      = 4,
   parameter int MAX_OUTST = 4
)(
   input  logic             clock,
   input  logic             reset,
   mm_port_arbiter_if.slave bus
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int TAG_W = IDX_W + ID_W;
   localparam int CNT_W = $clog2(MAX_OUTST + 1);

   stage_state_e       r_state;
   stage_state_e       w_state_nxt;
   logic [IDX_W-1:0]   r_rr_ptr;
   mem_req_body_t      r_stage;
   logic [TAG_W-1:0]   r_stage_tag;
   logic [CNT_W-1:0]   r_rd_cnt [NUM_REQ];

   logic [NUM_REQ-1:0] r_res_valid;
   logic [ID_W-1:0]    r_res_id;
   mem_res_body_t      r_res;
   logic               r_err;

   logic [NUM_REQ-1:0] w_eligible;
   logic [NUM_REQ-1:0] w_sel;
   logic [NUM_REQ-1:0] w_grant;
   logic [NUM_REQ-1:0] w_inc;
   logic [NUM_REQ-1:0] w_dec;
   logic [NUM_REQ-1:0] w_res_hit;
   logic               w_found;
   logic               w_can_grant;
   logic               w_do_grant;
   logic               w_drain;
   logic               w_unexpected;
   logic [IDX_W-1:0]   w_win_idx;
   logic [IDX_W-1:0]   w_res_idx;

   assign w_res_idx = bus.mem_res_tag[TAG_W-1:ID_W];

   // Writes never occupy a read slot, so only reads are throttled.
   always_comb begin
      w_eligible = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_eligible[i] = bus.req_valid[i] &&
                         (bus.req_is_write[i] || (r_rd_cnt[i] < CNT_W'(MAX_OUTST)));
      end
   end

   mm_port_arbiter_rr_select #(
      .N     (NUM_REQ),
      .PTR_W (IDX_W)
   ) u_rr_select (
      .i_eligible (w_eligible),
      .i_ptr      (r_rr_ptr),
      .o_grant    (w_sel),
      .o_found    (w_found)
   );

   // A full stage can take a new request only in the cycle it drains.
   assign w_can_grant = (r_state == ST_EMPTY) || bus.mem_req_ready;
   assign w_drain     = (r_state == ST_FULL) && bus.mem_req_ready;
   assign w_do_grant  = w_can_grant && w_found;
   assign w_grant     = w_can_grant ? w_sel : '0;

   always_comb begin
      w_win_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_sel[i]) begin
            w_win_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: if (w_do_grant)              w_state_nxt = ST_FULL;
         ST_FULL:  if (w_drain && !w_do_grant)  w_state_nxt = ST_EMPTY;
         default:                               w_state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= ST_EMPTY;
         r_rr_ptr    <= '0;
         r_stage     <= '0;
         r_stage_tag <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_do_grant) begin
            r_stage.is_write <= bus.req_is_write[w_win_idx];
            r_stage.paddr    <= bus.req_paddr[w_win_idx];
            r_stage.data     <= bus.req_data[w_win_idx];
            r_stage_tag      <= {w_win_idx, bus.req_id[w_win_idx]};
            r_rr_ptr         <= (w_win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;
         end
      end
   end

   // A response to an idle counter is flagged rather than decremented, so the
   // counter can never wrap below zero.
   always_comb begin
      w_res_hit = '0;
      w_inc     = '0;
      w_dec     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_res_hit[i] = bus.mem_res_valid && (w_res_idx == IDX_W'(i));
         w_inc[i]     = w_grant[i] && !bus.req_is_write[i];
         w_dec[i]     = w_res_hit[i] && (r_rd_cnt[i] != '0);
      end
   end

   assign w_unexpected = |(w_res_hit & ~w_dec);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            r_rd_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (w_inc[i] && !w_dec[i]) begin
               r_rd_cnt[i] <= r_rd_cnt[i] + 1'b1;
            end else if (!w_inc[i] && w_dec[i]) begin
               r_rd_cnt[i] <= r_rd_cnt[i] - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_res_valid <= '0;
         r_res_id    <= '0;
         r_res       <= '0;
         r_err       <= 1'b0;
      end else begin
         r_res_valid <= w_res_hit;
         r_err       <= r_err | w_unexpected;
         if (bus.mem_res_valid) begin
            r_res_id    <= bus.mem_res_tag[ID_W-1:0];
            r_res.paddr <= bus.mem_res_paddr;
            r_res.data  <= bus.mem_res_data;
         end
      end
   end

   assign bus.req_ready        = w_grant;
   assign bus.mem_req_valid    = (r_state == ST_FULL);
   assign bus.mem_req_is_write = r_stage.is_write;
   assign bus.mem_req_paddr    = r_stage.paddr;
   assign bus.mem_req_data     = r_stage.data;
   assign bus.mem_req_tag      = r_stage_tag;
   assign bus.res_valid        = r_res_valid;
   assign bus.res_id           = r_res_id;
   assign bus.res_paddr        = r_res.paddr;
   assign bus.res_data         = r_res.data;
   assign bus.err_unexpected   = r_err;

endmodule

// File: tb/tb_mm_port_arbiter.sv
// tb/tb_mm_port_arbiter.sv - self-checking bench for mm_port_arbiter
module tb_mm_port_arbiter;
   import mm_port_arbiter_pkg::*;

   localparam int NR   = 4;
   localparam int IDW  = 4;
   localparam int MAXO = 4;
   localparam int TAGW = 6;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   mm_port_arbiter_if #(.NUM_REQ(NR), .ID_W(IDW)) bus_if ();

   mm_port_arbiter #(.NUM_REQ(NR), .ID_W(IDW), .MAX_OUTST(MAXO)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state, kept at transaction level.
   int               m_ptr;
   int               m_cnt [NR];
   bit               m_full;
   logic             m_wr;
   logic [63:0]      m_paddr;
   logic [TAGW-1:0]  m_tag;
   logic [127:0]     m_data;
   logic [NR-1:0]    m_res_valid;
   logic [IDW-1:0]   m_res_id;
   logic [63:0]      m_res_paddr;
   logic [127:0]     m_res_data;
   bit               m_err;

   logic [NR-1:0]    exp_ready;
   logic [NR-1:0]    obs_ready;

   task automatic model_reset();
      m_ptr = 0;
      for (int i = 0; i < NR; i++) m_cnt[i] = 0;
      m_full = 0; m_wr = 0; m_paddr = '0; m_tag = '0; m_data = '0;
      m_res_valid = '0; m_res_id = '0; m_res_paddr = '0; m_res_data = '0;
      m_err = 0;
   endtask

   // Grant rule: nobody when the stage is stuck; otherwise first valid
   // requester scanning upward from the pointer, reads only below the limit.
   function automatic logic [NR-1:0] model_ready();
      logic [NR-1:0] r;
      int w;
      r = '0;
      if (m_full && !bus_if.mem_req_ready) return r;
      for (int k = 0; k < NR; k++) begin
         w = (m_ptr + k) % NR;
         if (bus_if.req_valid[w] && (bus_if.req_is_write[w] || m_cnt[w] < MAXO)) begin
            r[w] = 1'b1;
            return r;
         end
      end
      return r;
   endfunction

   task automatic model_edge(input logic [NR-1:0] g);
      int win;
      int idx;
      win = -1;
      for (int k = 0; k < NR; k++) if (g[k]) win = k;
      if (bus_if.mem_res_valid) begin
         idx = int'(bus_if.mem_res_tag[TAGW-1:IDW]);
         if (m_cnt[idx] == 0) m_err = 1;
         else m_cnt[idx] = m_cnt[idx] - 1;
         m_res_valid = '0;
         m_res_valid[idx] = 1'b1;
         m_res_id    = bus_if.mem_res_tag[IDW-1:0];
         m_res_paddr = bus_if.mem_res_paddr;
         m_res_data  = bus_if.mem_res_data;
      end else begin
         m_res_valid = '0;
      end
      if (win >= 0) begin
         if (!bus_if.req_is_write[win]) m_cnt[win] = m_cnt[win] + 1;
         m_full  = 1;
         m_wr    = bus_if.req_is_write[win];
         m_paddr = bus_if.req_paddr[win];
         m_data  = bus_if.req_data[win];
         m_tag   = {2'(win), bus_if.req_id[win]};
         m_ptr   = (win + 1) % NR;
      end else if (m_full && bus_if.mem_req_ready) begin
         m_full = 0;
      end
   endtask

   task automatic clear_inputs();
      bus_if.req_valid     = '0;
      bus_if.req_is_write  = '0;
      bus_if.req_paddr     = '0;
      bus_if.req_id        = '0;
      bus_if.req_data      = '0;
      bus_if.mem_req_ready = 1'b0;
      bus_if.mem_res_valid = 1'b0;
      bus_if.mem_res_tag   = '0;
      bus_if.mem_res_paddr = '0;
      bus_if.mem_res_data  = '0;
   endtask

   // Called just after a posedge with inputs set; samples req_ready before the
   // next edge, advances the model at the edge, returns 1 time unit after it.
   task automatic tick();
      #2;
      exp_ready = model_ready();
      obs_ready = bus_if.req_ready;
      @(posedge clock);
      model_edge(exp_ready);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      @(posedge clock);
      @(posedge clock);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   function automatic logic [15:0] dut_cnts();
      logic [15:0] v;
      for (int i = 0; i < NR; i++) v[i*4 +: 4] = 4'(dut.r_rd_cnt[i]);
      return v;
   endfunction

   function automatic logic [15:0] model_cnts();
      logic [15:0] v;
      for (int i = 0; i < NR; i++) v[i*4 +: 4] = 4'(m_cnt[i]);
      return v;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      clear_inputs();
      @(posedge clock);
      #1;
      n_cmp++;
      if ({bus_if.mem_req_valid, bus_if.mem_req_is_write, bus_if.mem_req_paddr,
           bus_if.mem_req_tag, bus_if.mem_req_data} !== '0) begin
         n_bad++;
         $display("FAIL reset_mem_req: got valid=%b tag=%h paddr=%h expected all zero",
                  bus_if.mem_req_valid, bus_if.mem_req_tag, bus_if.mem_req_paddr);
      end
      n_cmp++;
      if ({bus_if.res_valid, bus_if.res_id, bus_if.res_paddr, bus_if.res_data} !== '0) begin
         n_bad++;
         $display("FAIL reset_res: got res_valid=%b res_id=%h expected zero", bus_if.res_valid, bus_if.res_id);
      end
      n_cmp++;
      if (bus_if.err_unexpected !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_err: got %b expected 0", bus_if.err_unexpected);
      end
      n_cmp++;
      if (dut_cnts() !== 16'h0) begin
         n_bad++;
         $display("FAIL reset_cnt: got %h expected 0000", dut_cnts());
      end
      n_cmp++;
      if (bus_if.req_ready !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_ready: got %b expected 0000", bus_if.req_ready);
      end
      #3;
      reset = 1'b0;
      model_reset();
      @(posedge clock);
      #1;
   endtask

   task automatic test_rr_order();
      do_reset();
      bus_if.mem_req_ready = 1'b1;
      for (int i = 0; i < NR; i++) begin
         bus_if.req_valid[i] = 1'b1;
         bus_if.req_id[i]    = 4'(i + 5);
         bus_if.req_paddr[i] = 64'(i + 1) << 4;
      end
      for (int k = 0; k < NR; k++) begin
         tick();
         n_cmp++;
         if (obs_ready !== (4'b0001 << k)) begin
            n_bad++;
            $display("FAIL rr_ready[%0d]: got %b expected %b", k, obs_ready, 4'b0001 << k);
         end
         n_cmp++;
         if (bus_if.mem_req_valid !== 1'b1 || bus_if.mem_req_tag !== {2'(k), 4'(k + 5)}) begin
            n_bad++;
            $display("FAIL rr_tag[%0d]: got valid=%b tag=%h expected valid=1 tag=%h",
                     k, bus_if.mem_req_valid, bus_if.mem_req_tag, {2'(k), 4'(k + 5)});
         end
      end
   endtask

   task automatic test_outstanding_limit();
      do_reset();
      bus_if.mem_req_ready = 1'b1;
      bus_if.req_valid[2]  = 1'b1;
      bus_if.req_id[2]     = 4'h3;
      for (int k = 0; k < MAXO; k++) begin
         tick();
         n_cmp++;
         if (obs_ready !== 4'b0100) begin
            n_bad++;
            $display("FAIL limit_read[%0d]: got %b expected 0100", k, obs_ready);
         end
      end
      tick();
      n_cmp++;
      if (obs_ready !== 4'b0000) begin
         n_bad++;
         $display("FAIL limit_block: got %b expected 0000", obs_ready);
      end
      n_cmp++;
      if (dut_cnts() !== 16'h0400) begin
         n_bad++;
         $display("FAIL limit_cnt: got %h expected 0400", dut_cnts());
      end
      bus_if.req_is_write[2] = 1'b1;
      tick();
      n_cmp++;
      if (obs_ready !== 4'b0100 || bus_if.mem_req_is_write !== 1'b1) begin
         n_bad++;
         $display("FAIL limit_write: got ready=%b is_write=%b expected 0100/1", obs_ready, bus_if.mem_req_is_write);
      end
      bus_if.req_is_write[2] = 1'b0;
      bus_if.mem_res_valid   = 1'b1;
      bus_if.mem_res_tag     = {2'd2, 4'h3};
      tick();
      bus_if.mem_res_valid   = 1'b0;
      n_cmp++;
      if (obs_ready !== 4'b0000) begin
         n_bad++;
         $display("FAIL limit_res_cycle: got %b expected 0000", obs_ready);
      end
      tick();
      n_cmp++;
      if (obs_ready !== 4'b0100) begin
         n_bad++;
         $display("FAIL limit_after_res: got %b expected 0100", obs_ready);
      end
   endtask

   task automatic test_backpressure();
      logic [63:0]  held_paddr;
      logic [127:0] held_data;
      do_reset();
      held_paddr = 64'h0000_0000_0000_0A00;
      held_data  = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
      bus_if.req_valid[1] = 1'b1;
      bus_if.req_id[1]    = 4'h1;
      bus_if.req_paddr[1] = held_paddr;
      bus_if.req_data[1]  = held_data;
      tick();
      n_cmp++;
      if (obs_ready !== 4'b0010) begin
         n_bad++;
         $display("FAIL bp_first: got %b expected 0010", obs_ready);
      end
      bus_if.req_paddr[1] = 64'h0000_0000_0000_0B00;
      bus_if.req_data[1]  = '0;
      bus_if.req_valid[3] = 1'b1;
      bus_if.req_id[3]    = 4'h7;
      bus_if.req_paddr[3] = 64'h300;
      for (int k = 0; k < 5; k++) begin
         tick();
         n_cmp++;
         if (obs_ready !== 4'b0000) begin
            n_bad++;
            $display("FAIL bp_ready[%0d]: got %b expected 0000", k, obs_ready);
         end
         n_cmp++;
         if (bus_if.mem_req_valid !== 1'b1 || bus_if.mem_req_tag !== 6'h11 ||
             bus_if.mem_req_paddr !== held_paddr || bus_if.mem_req_data !== held_data ||
             bus_if.mem_req_is_write !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_hold[%0d]: got valid=%b tag=%h paddr=%h expected 1/11/%h",
                     k, bus_if.mem_req_valid, bus_if.mem_req_tag, bus_if.mem_req_paddr, held_paddr);
         end
      end
      bus_if.mem_req_ready = 1'b1;
      tick();
      n_cmp++;
      if (obs_ready !== 4'b1000) begin
         n_bad++;
         $display("FAIL bp_refill_ready: got %b expected 1000", obs_ready);
      end
      n_cmp++;
      if (bus_if.mem_req_valid !== 1'b1 || bus_if.mem_req_tag !== 6'h37 || bus_if.mem_req_paddr !== 64'h300) begin
         n_bad++;
         $display("FAIL bp_refill_stage: got valid=%b tag=%h paddr=%h expected 1/37/300",
                  bus_if.mem_req_valid, bus_if.mem_req_tag, bus_if.mem_req_paddr);
      end
   endtask

   task automatic test_response();
      do_reset();
      bus_if.mem_res_valid = 1'b1;
      bus_if.mem_res_tag   = 6'h1A;
      bus_if.mem_res_paddr = 64'h40;
      bus_if.mem_res_data  = 128'h1234;
      tick();
      bus_if.mem_res_valid = 1'b0;
      n_cmp++;
      if (bus_if.res_valid !== 4'b0010) begin
         n_bad++;
         $display("FAIL resp_valid: got %b expected 0010", bus_if.res_valid);
      end
      n_cmp++;
      if (bus_if.res_id !== 4'hA || bus_if.res_data !== 128'h1234 || bus_if.res_paddr !== 64'h40) begin
         n_bad++;
         $display("FAIL resp_fields: got id=%h data=%h paddr=%h expected a/1234/40",
                  bus_if.res_id, bus_if.res_data, bus_if.res_paddr);
      end
      tick();
      n_cmp++;
      if (bus_if.res_valid !== 4'b0000) begin
         n_bad++;
         $display("FAIL resp_single: got %b expected 0000", bus_if.res_valid);
      end
   endtask

   task automatic test_unexpected();
      do_reset();
      bus_if.mem_res_valid = 1'b1;
      bus_if.mem_res_tag   = {2'd3, 4'h0};
      tick();
      bus_if.mem_res_valid = 1'b0;
      n_cmp++;
      if (bus_if.err_unexpected !== 1'b1 || bus_if.res_valid !== 4'b1000) begin
         n_bad++;
         $display("FAIL unexp_flag: got err=%b res_valid=%b expected 1/1000", bus_if.err_unexpected, bus_if.res_valid);
      end
      n_cmp++;
      if (dut_cnts() !== 16'h0000) begin
         n_bad++;
         $display("FAIL unexp_no_underflow: got %h expected 0000", dut_cnts());
      end
      tick();
      tick();
      n_cmp++;
      if (bus_if.err_unexpected !== 1'b1) begin
         n_bad++;
         $display("FAIL unexp_sticky: got %b expected 1", bus_if.err_unexpected);
      end
      bus_if.mem_req_ready = 1'b1;
      bus_if.req_valid[0]  = 1'b1;
      tick();
      n_cmp++;
      if (dut_cnts() !== 16'h0001) begin
         n_bad++;
         $display("FAIL same_cycle_pre: got %h expected 0001", dut_cnts());
      end
      bus_if.mem_res_valid = 1'b1;
      bus_if.mem_res_tag   = {2'd0, 4'h0};
      tick();
      bus_if.mem_res_valid = 1'b0;
      n_cmp++;
      if (obs_ready !== 4'b0001 || dut_cnts() !== 16'h0001) begin
         n_bad++;
         $display("FAIL same_cycle_cnt: got ready=%b cnt=%h expected 0001/0001", obs_ready, dut_cnts());
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus_if.mem_req_ready = 1'b1;
      bus_if.req_valid     = 4'b0110;
      tick();
      tick();
      bus_if.mem_req_ready = 1'b0;
      tick();
      n_cmp++;
      if (bus_if.mem_req_valid !== 1'b1 || dut_cnts() !== 16'h0110) begin
         n_bad++;
         $display("FAIL rstmid_pre: got valid=%b cnt=%h expected 1/0110", bus_if.mem_req_valid, dut_cnts());
      end
      #2;
      reset = 1'b1;
      #1;
      n_cmp++;
      if (bus_if.mem_req_valid !== 1'b0 || dut_cnts() !== 16'h0000) begin
         n_bad++;
         $display("FAIL rstmid_async: got valid=%b cnt=%h expected 0/0000", bus_if.mem_req_valid, dut_cnts());
      end
      clear_inputs();
      @(posedge clock);
      #1;
      reset = 1'b0;
      model_reset();
      bus_if.req_valid     = 4'b1111;
      bus_if.mem_req_ready = 1'b1;
      tick();
      n_cmp++;
      if (obs_ready !== 4'b0001) begin
         n_bad++;
         $display("FAIL rstmid_first_grant: got %b expected 0001", obs_ready);
      end
   endtask

   task automatic test_random();
      int idx;
      do_reset();
      for (int c = 0; c < 800; c++) begin
         bus_if.req_valid = 4'($urandom);
         for (int i = 0; i < NR; i++) begin
            bus_if.req_is_write[i] = ($urandom % 4 == 0);
            bus_if.req_id[i]       = 4'($urandom);
            bus_if.req_paddr[i]    = {$urandom, $urandom} & ~64'hF;
            bus_if.req_data[i]     = {$urandom, $urandom, $urandom, $urandom};
         end
         bus_if.mem_req_ready = ($urandom % 4 != 0);
         idx = $urandom % NR;
         bus_if.mem_res_valid = ($urandom % 3 == 0) && (m_cnt[idx] > 0 || $urandom % 10 == 0);
         bus_if.mem_res_tag   = {2'(idx), 4'($urandom)};
         bus_if.mem_res_paddr = {$urandom, $urandom} & ~64'hF;
         bus_if.mem_res_data  = {$urandom, $urandom, $urandom, $urandom};
         tick();
         n_cmp++;
         if (obs_ready !== exp_ready) begin
            n_bad++;
            $display("FAIL rnd_ready[%0d]: got %b expected %b", c, obs_ready, exp_ready);
         end
         n_cmp++;
         if (bus_if.mem_req_valid !== m_full) begin
            n_bad++;
            $display("FAIL rnd_mem_valid[%0d]: got %b expected %b", c, bus_if.mem_req_valid, m_full);
         end
         if (m_full) begin
            n_cmp++;
            if (bus_if.mem_req_tag !== m_tag || bus_if.mem_req_paddr !== m_paddr ||
                bus_if.mem_req_data !== m_data || bus_if.mem_req_is_write !== m_wr) begin
               n_bad++;
               $display("FAIL rnd_mem_fields[%0d]: got tag=%h paddr=%h wr=%b expected tag=%h paddr=%h wr=%b",
                        c, bus_if.mem_req_tag, bus_if.mem_req_paddr, bus_if.mem_req_is_write, m_tag, m_paddr, m_wr);
            end
         end
         n_cmp++;
         if (bus_if.res_valid !== m_res_valid) begin
            n_bad++;
            $display("FAIL rnd_res_valid[%0d]: got %b expected %b", c, bus_if.res_valid, m_res_valid);
         end
         if (m_res_valid != '0) begin
            n_cmp++;
            if (bus_if.res_id !== m_res_id || bus_if.res_paddr !== m_res_paddr || bus_if.res_data !== m_res_data) begin
               n_bad++;
               $display("FAIL rnd_res_fields[%0d]: got id=%h paddr=%h expected id=%h paddr=%h",
                        c, bus_if.res_id, bus_if.res_paddr, m_res_id, m_res_paddr);
            end
         end
         n_cmp++;
         if (bus_if.err_unexpected !== m_err) begin
            n_bad++;
            $display("FAIL rnd_err[%0d]: got %b expected %b", c, bus_if.err_unexpected, m_err);
         end
         n_cmp++;
         if (dut_cnts() !== model_cnts()) begin
            n_bad++;
            $display("FAIL rnd_cnt[%0d]: got %h expected %h", c, dut_cnts(), model_cnts());
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      model_reset();
      test_reset();
      test_rr_order();
      test_outstanding_limit();
      test_backpressure();
      test_response();
      test_unexpected();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mm_port_arbiter.md
MM_PORT_ARBITER -- requirements
Module: mm_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of upstream requesters (page walkers plus L2 ports).
REQ-002 SHALL have parameter ID_W, default 4, upstream request id width.
REQ-003 SHALL have parameter MAX_OUTST, default 4, maximum outstanding reads per requester.
REQ-004 SHALL have port clock  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester request valid.
REQ-007 SHALL have port req_ready  output  NUM_REQ  per-requester accept; a transfer occurs when valid and ready are both high.
REQ-008 SHALL have ports req_is_write / req_paddr / req_id / req_data  input  NUM_REQ x 1 / 64 / ID_W / 128  request fields; paddr is 16-byte aligned.
REQ-009 SHALL have ports res_valid  output  NUM_REQ, and res_id / res_paddr / res_data  output  ID_W / 64 / 128  shared read-response fields.
REQ-010 SHALL have ports mem_req_valid  output  1, mem_req_ready  input  1, and mem_req_is_write / mem_req_paddr / mem_req_tag / mem_req_data  output  1 / 64 / TAG_W / 128  downstream memory request; TAG_W = clog2(NUM_REQ) + ID_W.
REQ-011 SHALL have ports mem_res_valid  input  1, and mem_res_tag / mem_res_paddr / mem_res_data  input  TAG_W / 64 / 128  downstream read response.
REQ-012 SHALL have port err_unexpected  output  1  sticky flag for a response to a requester with no outstanding reads.

Function
REQ-013 SHALL hold one request in a single-entry output stage with states EMPTY and FULL; mem_req_valid = (state == FULL).
REQ-014 SHALL be able to grant in a cycle only when the stage is EMPTY, or FULL with mem_req_ready high (drain and refill in the same cycle).
REQ-015 SHALL treat a requester as eligible when req_valid is high, and additionally its read counter is below MAX_OUTST if the request is a read; writes are always eligible.
REQ-016 SHALL select exactly one eligible requester by round-robin starting at pointer rr_ptr, and drive req_ready high only for the winner, combinationally.
REQ-017 SHALL set rr_ptr to (winner + 1) mod NUM_REQ after each grant and leave it unchanged when there is no grant.
REQ-018 SHALL register the winner's fields into the stage with mem_req_tag = {winner index, req_id}; a request accepted in cycle N appears on the mem_req_* outputs in cycle N+1.
REQ-019 SHALL hold all mem_req_* outputs stable while FULL and mem_req_ready is low.
REQ-020 SHALL go FULL to EMPTY on a drain with no grant, and stay FULL on a drain with a grant.
REQ-021 SHALL increment the winner's read counter on a read grant and decrement the indexed counter on mem_res_valid; on a simultaneous increment and decrement of the same counter, the counter is unchanged.
REQ-022 SHALL register responses: mem_res_valid in cycle M produces, in cycle M+1, res_valid one-hot at tag[TAG_W-1:ID_W], with res_id = tag[ID_W-1:0] and paddr/data passed through.
REQ-023 SHALL generate no upstream response for writes.
REQ-024 SHALL set err_unexpected on mem_res_valid targeting a requester whose counter is 0, and SHALL NOT decrement that counter (no underflow); the response is still forwarded.

Reset
REQ-025 SHALL on reset force: state EMPTY; rr_ptr 0; all counters 0; res_valid 0; err_unexpected 0; mem_req_* data fields and res fields 0.
REQ-026 SHALL discard any buffered request when reset asserts mid-operation; nothing is replayed after reset.

Structure
REQ-027 SHALL take the request and response struct typedefs, NUM_REQ, and the 128-bit block width from the shared memory-interface package.
REQ-028 SHALL place the round-robin selector in one sub-module, rr_select (inputs eligible vector and pointer; outputs one-hot grant and found).

Verification
REQ-029 SHALL cover: all 4 requesters issue reads at once with rr_ptr=0 and mem_req_ready=1 -> grants in order 0,1,2,3 on consecutive cycles; mem_req_tag[5:4] = 0,1,2,3.
REQ-030 SHALL cover: requester 2 issues 4 reads with no responses, then a 5th read -> 5th read not granted; a write from requester 2 is granted; after one response with tag[5:4]=2, the 5th read is granted.
REQ-031 SHALL cover: mem_req_ready held 0 for 5 cycles while FULL -> mem_req_* unchanged and req_ready all 0; when ready rises, drain and next grant occur in the same cycle.
REQ-032 SHALL cover: mem_res_valid with tag {1, 4'hA} and data 128'h1234 -> next cycle res_valid=4'b0010, res_id=4'hA, res_data=128'h1234.
REQ-033 SHALL cover: a response to requester 3 with counter 0 -> err_unexpected=1 stays high and counter stays 0; same-cycle read grant and response for requester 0 -> counter unchanged.
REQ-034 SHALL cover: reset asserted while FULL with outstanding reads -> mem_req_valid=0 and all counters 0 immediately, and the first grant after reset goes to requester 0.
